// File: rtl/header_sender.sv
`default_nettype none
// ============================================================================
//  Module   : header_sender
//  Purpose  : Streams a block header byte-by-byte into a UART transmitter,
//             then collects a fixed number of response bytes from a UART
//             receiver and presents them as a nonce. If no response byte
//             arrives within the timeout window, the job is aborted.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             start, header_in      - job request and header word (byte 0 in MSBs)
//             tx_byte, tx_wr_en     - byte and write strobe to the UART transmitter
//             tx_busy               - UART transmitter busy flag
//             rx_data, rx_rdy       - UART receiver byte and byte-ready flag
//             rx_rdy_clr            - one-cycle clear to the UART receiver
//             busy                  - high whenever a job is in progress
//             nonce_out/nonce_valid - assembled nonce and its update pulse
//             timeout               - one-cycle pulse on job abort
//  Revision : 1.0 - initial release
// ============================================================================
module header_sender #(
    parameter int HEADER_BYTES   = 80,
    parameter int NONCE_BYTES    = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [HEADER_BYTES*8-1:0] header_in,
    output logic [7:0]                tx_byte,
    output logic                      tx_wr_en,
    input  logic                      tx_busy,
    input  logic [7:0]                rx_data,
    input  logic                      rx_rdy,
    output logic                      rx_rdy_clr,
    output logic                      busy,
    output logic [31:0]               nonce_out,
    output logic                      nonce_valid,
    output logic                      timeout
);

    localparam int HDR_W  = HEADER_BYTES * 8;
    localparam int BCNT_W = $clog2(HEADER_BYTES + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BCNT_W-1:0] HDR_COUNT     = BCNT_W'(HEADER_BYTES);
    localparam logic [BCNT_W-1:0] NONCE_LAST_IX = BCNT_W'(NONCE_BYTES - 1);
    localparam logic [TCNT_W-1:0] TO_RELOAD     = TCNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        STROBE    = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        RECV      = 3'd5,
        DONE      = 3'd6,
        ABORT     = 3'd7
    } state_t;

    state_t              state;
    logic [HDR_W-1:0]    shreg;
    logic [BCNT_W-1:0]   byte_cnt;
    logic [TCNT_W-1:0]   to_cnt;
    logic [1:0]          ack_cnt;
    // Only the three most recent bytes need keeping; the fourth arrives
    // together with the decision to publish the nonce.
    logic [23:0]         nonce_asm;

    logic                rx_take;
    logic [31:0]         nonce_next;

    // A ready byte is taken only when no clear is already in flight, so the
    // receiver's still-high flag during the clear cycle is never re-captured.
    assign rx_take    = rx_rdy && !rx_rdy_clr;
    assign nonce_next = {nonce_asm, rx_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            byte_cnt    <= '0;
            to_cnt      <= '0;
            ack_cnt     <= '0;
            nonce_asm   <= '0;
            tx_byte     <= '0;
            tx_wr_en    <= 1'b0;
            rx_rdy_clr  <= 1'b0;
            busy        <= 1'b0;
            nonce_out   <= '0;
            nonce_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            tx_wr_en    <= 1'b0;
            nonce_valid <= 1'b0;
            timeout     <= 1'b0;
            // Any waiting byte is acknowledged in every state; only RECV
            // actually keeps the data.
            rx_rdy_clr  <= rx_take;

            case (state)
                IDLE: begin
                    if (start) begin
                        shreg     <= header_in;
                        byte_cnt  <= '0;
                        nonce_asm <= '0;
                        tx_byte   <= header_in[HDR_W-1 -: 8];
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (!tx_busy) begin
                        tx_wr_en <= 1'b1;   // high for the whole STROBE cycle
                        state    <= STROBE;
                    end
                end
                STROBE: begin
                    shreg    <= shreg << 8;
                    byte_cnt <= byte_cnt + 1'b1;
                    ack_cnt  <= '0;
                    state    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // Give the transmitter four cycles to raise busy; a
                    // transmitter that never reports busy must not stall us.
                    if (tx_busy || ack_cnt == 2'd3) begin
                        state <= WAIT_DONE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (byte_cnt < HDR_COUNT) begin
                            // Shift already happened in STROBE, so the MSBs
                            // now hold the next byte.
                            tx_byte <= shreg[HDR_W-1 -: 8];
                            state   <= LOAD;
                        end else begin
                            byte_cnt <= '0;
                            to_cnt   <= TO_RELOAD;
                            state    <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (rx_take) begin
                        nonce_asm <= nonce_next[23:0];
                        byte_cnt  <= byte_cnt + 1'b1;
                        to_cnt    <= TO_RELOAD;
                        if (byte_cnt == NONCE_LAST_IX) begin
                            // Publish on entry so the value and the pulse
                            // are both visible during the DONE cycle.
                            nonce_out   <= nonce_next;
                            nonce_valid <= 1'b1;
                            state       <= DONE;
                        end
                    end else if (to_cnt <= TCNT_W'(1)) begin
                        to_cnt  <= '0;
                        timeout <= 1'b1;
                        state   <= ABORT;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ABORT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_header_sender.sv
`default_nettype none
// ============================================================================
//  Module   : tb_header_sender
//  Purpose  : Self-checking bench for header_sender. A UART model answers
//             transmit strobes and supplies response bytes; a reference model
//             tracks which header byte must appear on each strobe, which nonce
//             must be published, and when a timeout pulse is due.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_header_sender;

    localparam int HB = 80;
    localparam int NB = 4;
    localparam int TO = 100;

    logic            clk        = 1'b0;
    logic            rst_n      = 1'b1;
    logic            start      = 1'b0;
    logic [HB*8-1:0] header_in  = '0;
    logic [7:0]      tx_byte;
    logic            tx_wr_en;
    logic            tx_busy    = 1'b0;
    logic [7:0]      rx_data    = 8'h00;
    logic            rx_rdy     = 1'b0;
    logic            rx_rdy_clr;
    logic            busy;
    logic [31:0]     nonce_out;
    logic            nonce_valid;
    logic            timeout;

    header_sender #(
        .HEADER_BYTES  (HB),
        .NONCE_BYTES   (NB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .header_in  (header_in),
        .tx_byte    (tx_byte),
        .tx_wr_en   (tx_wr_en),
        .tx_busy    (tx_busy),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .rx_rdy_clr (rx_rdy_clr),
        .busy       (busy),
        .nonce_out  (nonce_out),
        .nonce_valid(nonce_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [7:0]  hdr [HB];
    int          tx_idx       = 0;
    int          strobe_total = 0;
    int          clr_count    = 0;
    int          valid_count  = 0;
    int          abort_count  = 0;
    bit          tx_allowed   = 1'b0;
    bit          phase_resp   = 1'b0;
    bit          check_en     = 1'b0;
    bit          exp_pending  = 1'b0;
    bit          exp_abort    = 1'b0;
    logic [31:0] exp_nonce    = '0;
    logic [31:0] model_nonce  = '0;
    int          cyc          = 0;
    int          last_clr     = 0;
    bit          prev_wr      = 1'b0;
    bit          prev_clr     = 1'b0;

    // ---------------- UART model state ----------------
    int          busy_cnt   = 0;
    int          fixed_busy = 0;
    int          rx_wait    = 0;
    logic [7:0]  rx_b [$];
    int          rx_g [$];

    // UART model: transmitter goes busy after each strobe (occasionally never
    // acknowledges); receiver presents queued bytes and drops ready on clear.
    initial begin
        forever begin
            @(negedge clk);
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            if (tx_wr_en) begin
                if (fixed_busy > 0) begin
                    busy_cnt = fixed_busy;
                    tx_busy  = 1'b1;
                end else if ($urandom_range(7) != 0) begin
                    busy_cnt = $urandom_range(12, 3);
                    tx_busy  = 1'b1;
                end
            end
            if (rx_rdy && rx_rdy_clr) begin
                rx_rdy = 1'b0;
            end else if (!rx_rdy) begin
                if (rx_wait > 0) begin
                    rx_wait--;
                end else if (rx_b.size() > 0) begin
                    rx_data = rx_b.pop_front();
                    rx_wait = rx_g.pop_front();
                    rx_rdy  = 1'b1;
                end
            end
        end
    end

    // Compare process: runs every cycle while out of reset.
    always @(negedge clk) begin
        cyc++;
        if (check_en) begin
            if (tx_wr_en) begin
                chk("wr_one_cycle", prev_wr, 0);
                chk("wr_allowed", (tx_allowed && tx_idx < HB), 1);
                if (tx_idx < HB) chk("tx_byte", tx_byte, hdr[tx_idx]);
                chk("busy_in_job", busy, 1);
                tx_idx++;
                strobe_total++;
            end
            if (rx_rdy_clr) begin
                chk("clr_one_cycle", prev_clr, 0);
                last_clr = cyc;
                if (phase_resp) clr_count++;
            end
            if (nonce_valid) begin
                chk("valid_expected", exp_pending, 1);
                chk("nonce_value", nonce_out, exp_nonce);
                chk("valid_latency", (cyc - last_clr) <= 2, 1);
                model_nonce = exp_nonce;
                exp_pending = 1'b0;
                valid_count++;
            end else begin
                chk("nonce_hold", nonce_out, model_nonce);
            end
            if (timeout) begin
                chk("timeout_expected", exp_abort, 1);
                chk("timeout_latency", cyc - last_clr, TO);
                exp_abort = 1'b0;
                abort_count++;
            end
            prev_wr  = tx_wr_en;
            prev_clr = rx_rdy_clr;
        end
    end

    task automatic rand_hdr();
        for (int i = 0; i < HB; i++) hdr[i] = 8'($urandom);
    endtask

    task automatic launch_job();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_before_start", busy, 0);
        for (int i = 0; i < HB; i++) header_in[HB*8-1-8*i -: 8] = hdr[i];
        tx_idx     = 0;
        tx_allowed = 1'b1;
        phase_resp = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_job(input int nresp, input logic [31:0] resp,
                           input bit noise, input bit hold_start);
        int n;
        int v0;
        int a0;
        int s0;
        s0 = strobe_total;
        v0 = valid_count;
        a0 = abort_count;
        launch_job();
        if (noise) begin
            rx_wait = 150;
            rx_g.push_back(0);
            rx_b.push_back(8'h55);
        end
        repeat (30) @(negedge clk);
        start = 1'b1;                  // must be ignored mid-job
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (tx_idx < HB && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("header_strobes", tx_idx, HB);
        tx_allowed = 1'b0;
        repeat (8) @(negedge clk);
        n = 0;
        while ((tx_busy || rx_rdy || rx_b.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("noise_cleared", (rx_rdy || rx_b.size() != 0), 0);
        repeat (3) @(negedge clk);
        phase_resp = 1'b1;
        clr_count  = 0;
        if (nresp == NB) begin
            exp_nonce   = resp;
            exp_pending = 1'b1;
        end else begin
            exp_abort = 1'b1;
        end
        for (int k = 0; k < nresp; k++) begin
            rx_b.push_back(resp[31-8*k -: 8]);
            rx_g.push_back($urandom_range(20));
        end
        if (hold_start) start = 1'b1;  // held through the DONE cycle
        n = 0;
        while (!(nonce_valid || timeout) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("job_end_seen", n < 2000, 1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_end", busy, 0);
        chk("resp_clears", clr_count, nresp);
        chk("valid_pulses", valid_count - v0, (nresp == NB) ? 1 : 0);
        chk("abort_pulses", abort_count - a0, (nresp == NB) ? 0 : 1);
        phase_resp = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_restart", strobe_total - s0, HB);
        chk("idle_after_job", busy, 0);
        exp_pending = 1'b0;
        exp_abort   = 1'b0;
    endtask

    task automatic reset_mid_job();
        int n;
        rand_hdr();
        launch_job();
        n = 0;
        while (tx_idx < 40 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_byte_40", tx_idx, 40);
        repeat (2) @(negedge clk);
        #2;
        check_en = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_tx_wr_en", tx_wr_en, 0);
        chk("rst_rx_rdy_clr", rx_rdy_clr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_nonce_out", nonce_out, 0);
        chk("rst_nonce_valid", nonce_valid, 0);
        chk("rst_timeout", timeout, 0);
        tx_allowed  = 1'b0;
        tx_idx      = 0;
        busy_cnt    = 0;
        tx_busy     = 1'b0;
        rx_rdy      = 1'b0;
        rx_wait     = 0;
        rx_b.delete();
        rx_g.delete();
        model_nonce = '0;
        prev_wr     = 1'b0;
        prev_clr    = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n    = 1'b1;
        check_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_after_reset", busy, 0);
        chk("no_strobe_after_reset", tx_idx, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("init_tx_byte", tx_byte, 0);
        chk("init_tx_wr_en", tx_wr_en, 0);
        chk("init_rx_rdy_clr", rx_rdy_clr, 0);
        chk("init_busy", busy, 0);
        chk("init_nonce_out", nonce_out, 0);
        chk("init_nonce_valid", nonce_valid, 0);
        chk("init_timeout", timeout, 0);
        repeat (3) @(negedge clk);
        #2;
        rst_n    = 1'b1;
        check_en = 1'b1;

        // Counting header, fixed 10-cycle transmitter, stray 0x55 mid-header.
        fixed_busy = 10;
        for (int i = 0; i < HB; i++) hdr[i] = 8'(i);
        run_job(NB, 32'hDEADBEEF, 1'b1, 1'b0);
        chk("nonce_literal", nonce_out, 32'hDEADBEEF);
        chk("strobes_literal", strobe_total, 80);
        chk("clears_literal", clr_count, 4);
        fixed_busy = 0;

        // Only two response bytes: must abort, nonce kept.
        rand_hdr();
        run_job(2, $urandom, 1'b0, 1'b0);
        chk("nonce_kept_after_abort", nonce_out, 32'hDEADBEEF);

        // Start held across the DONE cycle.
        rand_hdr();
        run_job(NB, $urandom, 1'b1, 1'b1);

        reset_mid_job();
        chk("nonce_cleared_by_reset", nonce_out, 0);

        for (int r = 0; r < 3; r++) begin
            rand_hdr();
            run_job(NB, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        rand_hdr();
        run_job(1, $urandom, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
